// File: rtl/tof_sample_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tof_sample_collector: double-buffered per-channel ToF sample holding     |
// | registers feeding the memory-write FSM.                    Rev 1.0       |
// +--------------------------------------------------------------------------+
module tof_sample_collector #(
  parameter int N_TOF  = 8,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_TOF-1:0]          tof_valid,
  input  logic [N_TOF*DATA_W-1:0]   tof_data,
  input  logic                      wea,
  input  logic [IDX_W-1:0]          ToF_Index,
  input  logic                      clr_status,
  output logic [N_TOF-1:0]          ToF_dr,
  output logic [DATA_W-1:0]         mem_din,
  output logic [N_TOF-1:0]          overrun,
  output logic [7:0]                overrun_cnt,
  output logic                      proto_err
);

  localparam int CNT_W = $clog2(N_TOF + 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  logic                         wea_q;
  logic                         wr_act_q;
  logic [IDX_W-1:0]             wr_idx_q;
  logic [N_TOF-1:0]             overrun_q;
  logic [N_TOF-1:0]             overrun_d;
  logic [7:0]                   overrun_cnt_q;
  logic [7:0]                   overrun_cnt_d;
  logic                         proto_err_q;
  logic                         proto_err_d;

  logic                         w_wstart;
  logic                         w_wend;
  logic [N_TOF-1:0]             w_evt;
  logic [N_TOF-1:0]             w_perr;
  logic [N_TOF-1:0]             w_take;
  logic [N_TOF-1:0][DATA_W-1:0] w_main;
  logic [CNT_W-1:0]             w_evt_n;
  logic [8:0]                   w_sum;

  assign w_wstart = wea & ~wea_q;
  assign w_wend   = ~wea & wea_q & wr_act_q;

  for (genvar k = 0; k < N_TOF; k++) begin : g_ch
    state_e            state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] pend_q;
    logic              pend_v_q;
    logic              w_start_k;
    logic              w_end_k;
    logic              w_vld;
    logic [DATA_W-1:0] w_data;

    assign w_start_k = w_wstart & (ToF_Index == IDX_W'(k));
    assign w_end_k   = w_wend & (wr_idx_q == IDX_W'(k));
    assign w_vld     = tof_valid[k];
    assign w_data    = tof_data[k*DATA_W +: DATA_W];
    assign w_take[k] = w_start_k & (state_q == ST_FULL);
    assign w_perr[k] = w_start_k & (state_q != ST_FULL);
    assign w_evt[k]  = w_vld & (((state_q == ST_FULL) & ~w_start_k) |
                                ((state_q == ST_BUSY) & pend_v_q));
    assign ToF_dr[k] = (state_q == ST_FULL);
    assign w_main[k] = main_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q  <= ST_EMPTY;
        main_q   <= '0;
        pend_q   <= '0;
        pend_v_q <= 1'b0;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (w_vld) begin
              main_q  <= w_data;
              state_q <= ST_FULL;
            end
          end
          ST_FULL: begin
            // A sample landing on the write-start edge must not disturb main.
            if (w_start_k) begin
              state_q <= ST_BUSY;
              if (w_vld) begin
                pend_q   <= w_data;
                pend_v_q <= 1'b1;
              end
            end else if (w_vld) begin
              main_q <= w_data;
            end
          end
          ST_BUSY: begin
            if (w_end_k) begin
              pend_v_q <= 1'b0;
              if (w_vld) begin
                main_q  <= w_data;
                state_q <= ST_FULL;
              end else if (pend_v_q) begin
                main_q  <= pend_q;
                state_q <= ST_FULL;
              end else begin
                state_q <= ST_EMPTY;
              end
            end else if (w_vld) begin
              pend_q   <= w_data;
              pend_v_q <= 1'b1;
            end
          end
          default: state_q <= ST_EMPTY;
        endcase
      end
    end
  end

  assign mem_din = w_main[ToF_Index];

  always_comb begin
    w_evt_n = '0;
    for (int i = 0; i < N_TOF; i++) begin
      w_evt_n = w_evt_n + CNT_W'(w_evt[i]);
    end
  end

  // Clear is applied first so same-edge events survive it.
  assign w_sum         = {1'b0, (clr_status ? 8'd0 : overrun_cnt_q)} + 9'(w_evt_n);
  assign overrun_cnt_d = w_sum[8] ? 8'hFF : w_sum[7:0];
  assign overrun_d     = (clr_status ? '0 : overrun_q) | w_evt;
  assign proto_err_d   = (clr_status ? 1'b0 : proto_err_q) | (|w_perr);

  // wea_q resets high so a wea already asserted at release is not a start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wea_q         <= 1'b1;
      wr_act_q      <= 1'b0;
      wr_idx_q      <= '0;
      overrun_q     <= '0;
      overrun_cnt_q <= 8'd0;
      proto_err_q   <= 1'b0;
    end else begin
      wea_q         <= wea;
      overrun_q     <= overrun_d;
      overrun_cnt_q <= overrun_cnt_d;
      proto_err_q   <= proto_err_d;
      if (w_wend) begin
        wr_act_q <= 1'b0;
      end else if (|w_take) begin
        wr_act_q <= 1'b1;
        wr_idx_q <= ToF_Index;
      end
    end
  end

  assign overrun     = overrun_q;
  assign overrun_cnt = overrun_cnt_q;
  assign proto_err   = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tof_sample_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tof_sample_collector: directed and randomized checks of the collector.|
// |                                                            Rev 1.0       |
// +--------------------------------------------------------------------------+
module tb_tof_sample_collector;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    tof_valid = '0;
  logic [N*DW-1:0] tof_data = '0;
  logic            wea = 1'b0;
  logic [IW-1:0]   ToF_Index = '0;
  logic            clr_status = 1'b0;
  logic [N-1:0]    ToF_dr;
  logic [DW-1:0]   mem_din;
  logic [N-1:0]    overrun;
  logic [7:0]      overrun_cnt;
  logic            proto_err;

  int tests_run = 0;
  int tests_failed = 0;

  tof_sample_collector #(.N_TOF(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .tof_valid(tof_valid), .tof_data(tof_data),
    .wea(wea), .ToF_Index(ToF_Index), .clr_status(clr_status),
    .ToF_dr(ToF_dr), .mem_din(mem_din), .overrun(overrun),
    .overrun_cnt(overrun_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Transaction-level model: each channel holds an unwritten value, may be
  // under write, and may have one late arrival waiting behind the write.
  logic [DW-1:0] m_val [N];
  logic [DW-1:0] m_late [N];
  bit            m_ready [N];
  bit            m_inw [N];
  bit            m_latev [N];
  bit            m_prev_wea;
  bit            m_writing;
  int            m_widx;
  logic [N-1:0]  m_ovr;
  int            m_cnt;
  bit            m_perr;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_val[k] = '0; m_late[k] = '0;
      m_ready[k] = 0; m_inw[k] = 0; m_latev[k] = 0;
    end
    m_prev_wea = 1; m_writing = 0; m_widx = 0;
    m_ovr = '0; m_cnt = 0; m_perr = 0;
  endtask

  task automatic model_step();
    bit start, stop, accepted;
    int ev, idx;
    logic [DW-1:0] d;
    start = wea && !m_prev_wea;
    stop = !wea && m_prev_wea && m_writing;
    idx = int'(ToF_Index);
    ev = 0;
    accepted = 0;
    if (clr_status) begin m_ovr = '0; m_cnt = 0; m_perr = 0; end
    for (int k = 0; k < N; k++) begin
      d = tof_data[k*DW +: DW];
      if (m_inw[k]) begin
        if (tof_valid[k]) begin
          if (m_latev[k]) begin ev++; m_ovr[k] = 1'b1; end
          m_late[k] = d; m_latev[k] = 1;
        end
        if (stop && m_widx == k) begin
          m_inw[k] = 0;
          m_ready[k] = m_latev[k];
          if (m_latev[k]) m_val[k] = m_late[k];
          m_latev[k] = 0;
        end
      end else if (m_ready[k]) begin
        if (start && idx == k) begin
          m_inw[k] = 1; accepted = 1;
          if (tof_valid[k]) begin m_late[k] = d; m_latev[k] = 1; end
        end else if (tof_valid[k]) begin
          m_val[k] = d; ev++; m_ovr[k] = 1'b1;
        end
      end else if (tof_valid[k]) begin
        m_val[k] = d; m_ready[k] = 1;
      end
    end
    if (stop) m_writing = 0;
    if (start) begin
      if (accepted) begin m_writing = 1; m_widx = idx; end
      else m_perr = 1;
    end
    m_cnt = m_cnt + ev;
    if (m_cnt > 255) m_cnt = 255;
    m_prev_wea = wea;
  endtask

  function automatic logic [N-1:0] exp_dr();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = m_ready[k] && !m_inw[k];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    tof_valid = '0; wea = 1'b0; clr_status = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b0;
    model_reset();
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_sample(input int ch, input logic [DW-1:0] v);
    tof_valid[ch] = 1'b1;
    tof_data[ch*DW +: DW] = v;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    model_reset();
    #1;
    tests_run++; if (ToF_dr !== 8'h00) begin tests_failed++; $display("FAIL reset_dr: got %h want 00", ToF_dr); end
    tests_run++; if (mem_din !== 16'h0000) begin tests_failed++; $display("FAIL reset_din: got %h want 0000", mem_din); end
    tests_run++; if (overrun !== 8'h00) begin tests_failed++; $display("FAIL reset_ovr: got %h want 00", overrun); end
    tests_run++; if (overrun_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d want 0", overrun_cnt); end
    tests_run++; if (proto_err !== 1'b0) begin tests_failed++; $display("FAIL reset_perr: got %b want 0", proto_err); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    set_sample(3, 16'h1234);
    tick();
    tof_valid = '0;
    tests_run++; if (ToF_dr !== 8'h08) begin tests_failed++; $display("FAIL single_dr: got %h want 08", ToF_dr); end
    wea = 1'b1; ToF_Index = 3'd3;
    #1;
    tests_run++; if (mem_din !== 16'h1234) begin tests_failed++; $display("FAIL single_din1: got %h want 1234", mem_din); end
    tick();
    tests_run++; if (mem_din !== 16'h1234) begin tests_failed++; $display("FAIL single_din2: got %h want 1234", mem_din); end
    tests_run++; if (ToF_dr[3] !== 1'b0) begin tests_failed++; $display("FAIL single_dr_busy: got %b want 0", ToF_dr[3]); end
    tick();
    wea = 1'b0;
    tick();
    tests_run++; if (ToF_dr !== 8'h00) begin tests_failed++; $display("FAIL single_empty: got %h want 00", ToF_dr); end
    tests_run++; if (overrun_cnt !== 8'd0) begin tests_failed++; $display("FAIL single_cnt: got %0d want 0", overrun_cnt); end
  endtask

  task automatic test_overwrite();
    do_reset();
    set_sample(0, 16'h0011);
    tick();
    set_sample(0, 16'h0022);
    tick();
    tof_valid = '0;
    tests_run++; if (overrun !== 8'h01) begin tests_failed++; $display("FAIL ovw_flag: got %h want 01", overrun); end
    tests_run++; if (overrun_cnt !== 8'd1) begin tests_failed++; $display("FAIL ovw_cnt: got %0d want 1", overrun_cnt); end
    wea = 1'b1; ToF_Index = 3'd0;
    tick();
    tests_run++; if (mem_din !== 16'h0022) begin tests_failed++; $display("FAIL ovw_din: got %h want 0022", mem_din); end
    tick();
    wea = 1'b0;
    tick();
  endtask

  task automatic test_midwrite();
    do_reset();
    set_sample(5, 16'hAAAA);
    tick();
    tof_valid = '0;
    wea = 1'b1; ToF_Index = 3'd5;
    tick();
    set_sample(5, 16'hBBBB);
    tests_run++; if (mem_din !== 16'hAAAA) begin tests_failed++; $display("FAIL mid_din: got %h want AAAA", mem_din); end
    tick();
    tof_valid = '0; wea = 1'b0;
    tests_run++; if (mem_din !== 16'hAAAA) begin tests_failed++; $display("FAIL mid_din2: got %h want AAAA", mem_din); end
    tests_run++; if (ToF_dr[5] !== 1'b0) begin tests_failed++; $display("FAIL mid_dr_busy: got %b want 0", ToF_dr[5]); end
    tick();
    tests_run++; if (ToF_dr !== 8'h20) begin tests_failed++; $display("FAIL mid_dr_back: got %h want 20", ToF_dr); end
    tests_run++; if (mem_din !== 16'hBBBB) begin tests_failed++; $display("FAIL mid_din_new: got %h want BBBB", mem_din); end
    tests_run++; if (overrun !== 8'h00) begin tests_failed++; $display("FAIL mid_ovr: got %h want 00", overrun); end
  endtask

  task automatic test_busy_saturate();
    do_reset();
    set_sample(1, 16'h0101);
    tick();
    tof_valid = '0; wea = 1'b1; ToF_Index = 3'd1;
    tick();
    set_sample(1, 16'h0202);
    tick();
    wea = 1'b0; set_sample(1, 16'h0303);
    tick();
    tof_valid = '0;
    tests_run++; if (overrun_cnt !== 8'd1) begin tests_failed++; $display("FAIL busy_cnt: got %0d want 1", overrun_cnt); end
    tests_run++; if (overrun !== 8'h02) begin tests_failed++; $display("FAIL busy_ovr: got %h want 02", overrun); end
    tests_run++; if (mem_din !== 16'h0303) begin tests_failed++; $display("FAIL busy_din: got %h want 0303", mem_din); end
    for (int c = 0; c < 40; c++) begin
      for (int k = 0; k < N; k++) set_sample(k, DW'($urandom));
      tick();
    end
    tof_valid = '0;
    tests_run++; if (overrun_cnt !== 8'd255) begin tests_failed++; $display("FAIL sat_cnt: got %0d want 255", overrun_cnt); end
    tests_run++; if (overrun !== 8'hFF) begin tests_failed++; $display("FAIL sat_ovr: got %h want FF", overrun); end
    clr_status = 1'b1;
    set_sample(2, 16'h0C0C); set_sample(3, 16'h0D0D);
    tick();
    drive_idle();
    tests_run++; if (overrun_cnt !== 8'd2) begin tests_failed++; $display("FAIL clr_cnt: got %0d want 2", overrun_cnt); end
    tests_run++; if (overrun !== 8'h0C) begin tests_failed++; $display("FAIL clr_ovr: got %h want 0C", overrun); end
  endtask

  task automatic test_proto();
    do_reset();
    set_sample(1, 16'h4321);
    tick();
    tof_valid = '0; wea = 1'b1; ToF_Index = 3'd6;
    tick();
    tests_run++; if (proto_err !== 1'b1) begin tests_failed++; $display("FAIL proto_set: got %b want 1", proto_err); end
    tick();
    wea = 1'b0;
    tick();
    tests_run++; if (ToF_dr !== 8'h02) begin tests_failed++; $display("FAIL proto_states: got %h want 02", ToF_dr); end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    tests_run++; if (proto_err !== 1'b0) begin tests_failed++; $display("FAIL proto_clr: got %b want 0", proto_err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_sample(2, 16'h5555);
    tick();
    set_sample(2, 16'h6666);
    tick();
    wea = 1'b1; ToF_Index = 3'd2; set_sample(2, 16'h7777);
    tick();
    tof_valid = '0;
    tests_run++; if (overrun_cnt !== 8'd1) begin tests_failed++; $display("FAIL ar_pre_cnt: got %0d want 1", overrun_cnt); end
    reset = 1'b0;
    model_reset();
    #1;
    tests_run++; if (ToF_dr !== 8'h00) begin tests_failed++; $display("FAIL ar_dr: got %h want 00", ToF_dr); end
    tests_run++; if (mem_din !== 16'h0000) begin tests_failed++; $display("FAIL ar_din: got %h want 0000", mem_din); end
    tests_run++; if (overrun !== 8'h00) begin tests_failed++; $display("FAIL ar_ovr: got %h want 00", overrun); end
    tests_run++; if (overrun_cnt !== 8'd0) begin tests_failed++; $display("FAIL ar_cnt: got %0d want 0", overrun_cnt); end
    @(negedge clk);
    reset = 1'b1;
    set_sample(2, 16'h0A0A);
    tick();
    tof_valid = '0;
    tick();
    wea = 1'b0;
    tick();
    tests_run++; if (proto_err !== 1'b0) begin tests_failed++; $display("FAIL ar_nostart: got %b want 0", proto_err); end
    tests_run++; if (ToF_dr !== 8'h04) begin tests_failed++; $display("FAIL ar_dr_after: got %h want 04", ToF_dr); end
    tests_run++; if (mem_din !== 16'h0A0A) begin tests_failed++; $display("FAIL ar_din_after: got %h want 0A0A", mem_din); end
  endtask

  task automatic test_random();
    int wph;
    do_reset();
    wph = 0;
    for (int c = 0; c < 800; c++) begin
      tof_valid = N'($urandom & $urandom & $urandom);
      for (int k = 0; k < N; k++) tof_data[k*DW +: DW] = DW'($urandom);
      clr_status = ($urandom_range(39) == 0);
      if (wph == 0 && $urandom_range(3) == 0) begin
        wea = 1'b1; ToF_Index = IW'($urandom); wph = 1;
      end else if (wph == 1) begin
        wea = 1'b1; wph = 2;
      end else begin
        wea = 1'b0; wph = 0; ToF_Index = IW'($urandom);
      end
      tick();
      tests_run++; if (ToF_dr !== exp_dr()) begin tests_failed++; $display("FAIL rnd_dr c%0d: got %h want %h", c, ToF_dr, exp_dr()); end
      tests_run++; if (mem_din !== m_val[ToF_Index]) begin tests_failed++; $display("FAIL rnd_din c%0d: got %h want %h", c, mem_din, m_val[ToF_Index]); end
      tests_run++; if (overrun !== m_ovr) begin tests_failed++; $display("FAIL rnd_ovr c%0d: got %h want %h", c, overrun, m_ovr); end
      tests_run++; if (overrun_cnt !== 8'(m_cnt)) begin tests_failed++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, overrun_cnt, m_cnt); end
      tests_run++; if (proto_err !== m_perr) begin tests_failed++; $display("FAIL rnd_perr c%0d: got %b want %b", c, proto_err, m_perr); end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overwrite();
    test_midwrite();
    test_busy_saturate();
    test_proto();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/tof_sample_collector.md
Name: tof_sample_collector

Overview:
- Upstream neighbour of the ToF memory-write FSM. Captures per-sensor ranging results from the ToF acquisition logic into per-channel holding registers.
- Presents per-channel data-ready flags (ToF_dr) to the write FSM and muxes the selected channel's sample onto the memory data bus.
- Releases each channel once the write FSM has completed its two-cycle write strobe.
- Double-buffers each channel so a sample arriving mid-write is not lost, and counts overruns.

Parameters:
- N_TOF, 8, number of ToF sensor channels
- DATA_W, 16, sample width in bits
- IDX_W, 3, channel index width (clog2(N_TOF))

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous active-low reset (0 = reset)
- tof_valid  in  N_TOF  per-channel one-cycle strobe: new sample on tof_data slice
- tof_data  in  N_TOF*DATA_W  flattened samples; channel k = bits [k*DATA_W +: DATA_W]
- wea  in  1  write strobe from memory-write FSM (high exactly 2 consecutive cycles per write)
- ToF_Index  in  IDX_W  channel being written; stable whenever wea=1
- ToF_dr  out  N_TOF  channel k holds an unwritten sample
- mem_din  out  DATA_W  main register of channel ToF_Index (combinational mux)
- overrun  out  N_TOF  sticky: channel k lost a sample
- overrun_cnt  out  8  saturating count of lost samples, all channels
- proto_err  out  1  sticky: wea began on a channel not in FULL
- clr_status  in  1  synchronous clear of overrun, overrun_cnt and proto_err

Behaviour:
- Reset (reset=0, async): all channels EMPTY, main/pending registers 0, pend_v 0. ToF_dr=0, overrun=0, overrun_cnt=0, proto_err=0, mem_din=0.
- Per-channel FSM states: EMPTY, FULL, BUSY. ToF_dr[k]=1 only in FULL. Combinational decode, no added latency.
- A write start (wstart) for channel k is wea=1 AND ToF_Index=k AND wea was 0 on the previous sampled edge. This needs one registered wea_d.
- A write end (wend) for channel k is wea=0 AND wea_d=1 AND the latched write index = k. The write index is latched at wstart.
- EMPTY:
  - tof_valid[k] -> main<=data, go to FULL. ToF_dr rises the cycle after the strobe.
- FULL:
  - wstart -> BUSY. ToF_dr[k] falls the cycle after the first wea cycle, so it is low when the write FSM returns to IDLE.
  - tof_valid[k] without wstart -> main overwritten (latest wins), overrun event.
  - tof_valid[k] on the same edge as wstart -> sample goes to pending, pend_v<=1, no overrun. Main stays frozen.
- BUSY:
  - main is frozen; mem_din is stable for both wea cycles.
  - tof_valid[k] -> pending<=data, pend_v<=1. If pend_v was already 1, this is an overrun event.
  - wend with pend_v=1 -> main<=pending, pend_v<=0, go to FULL.
  - wend with pend_v=0 -> EMPTY.
  - tof_valid[k] on the wend edge -> treated as a BUSY-state sample (goes to pending), then the wend rule is applied. Net result: main<=newest sample, FULL, overrun event only if pend_v was already 1.
- wstart on a channel in EMPTY or BUSY: ignored for that channel's state, and proto_err<=1. No wend is tracked for it.
- Overrun events:
  - overrun[k]<=1.
  - overrun_cnt += number of channels with an event this cycle, saturating at 255.
- clr_status:
  - Clears overrun, proto_err and overrun_cnt.
  - Events on the same edge are applied after the clear: count = that cycle's events, and their flags are set.
- mem_din = main[ToF_Index] at all times; no registering.
- Reset asserted mid-write: everything returns to reset values immediately. After reset release, a wea already high is not a wstart until it has been seen low.

Test Plan:
- Single sample: tof_valid[3] with data 0x1234, then wea=1 for 2 cycles with ToF_Index=3 -> ToF_dr=0x08 the next cycle; mem_din=0x1234 during both wea cycles; ToF_dr[3] low from the 2nd wea cycle; state EMPTY after wea falls; overrun_cnt=0.
- Overwrite in FULL: valid[0]=0x0011 then valid[0]=0x0022 before any wea -> mem_din=0x0022 at write; overrun=0x01; overrun_cnt=1.
- Mid-write arrival: valid[5]=0xAAAA, wea starts, valid[5]=0xBBBB in the 2nd wea cycle -> 0xAAAA written; ToF_dr[5] re-asserts the cycle after wea falls with main=0xBBBB; no overrun.
- Double arrival in BUSY plus saturation: two valids during BUSY -> overrun_cnt +1. Then drive 300 overwrite events across channels -> overrun_cnt=255; clr_status with a simultaneous event on 2 channels -> overrun_cnt=2.
- Protocol error: wea with ToF_Index=6 while channel 6 is EMPTY -> proto_err=1; all channel states unchanged.
- Async reset: assert reset=0 in the 1st wea cycle with pend_v set -> ToF_dr, mem_din, overrun and overrun_cnt are 0 without waiting for a clk edge. After release with wea still high, no wstart occurs.
